// File: rtl/gate_tt_checker.sv
// Truth-table checker for a 2-input gate: steps {a,b} through 00..11, lets each
// vector settle for SETTLE cycles, then compares y with the expected table.
module gate_tt_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] expected,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    logic [1:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] exp_q, exp_d;
    logic       a_q, a_d, b_q, b_d;
    logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;

    logic       mism;
    logic [2:0] err_nxt;
    logic [3:0] mask_nxt;
    logic [1:0] idx_inc;

    assign mism     = (y != exp_q[idx_q]);
    assign err_nxt  = mism ? err_q + 3'd1 : err_q;
    assign mask_nxt = mism ? (mask_q | (4'b0001 << idx_q)) : mask_q;
    assign idx_inc  = idx_q + 2'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = S_RUN;
                    exp_d   = expected;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = 3'd0;
                    mask_d  = 4'd0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    err_d  = err_nxt;
                    mask_d = mask_nxt;
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_inc;
                        cnt_d      = 4'd0;
                        {a_d, b_d} = idx_inc;
                    end else begin
                        // Pass must see the final vector's result, so use err_nxt.
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_nxt == 3'd0);
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            exp_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: SETTLE=2 and SETTLE=0 instances driving a modelled
// gate; results predicted from truth table XOR expected table.
module tb_gate_tt_checker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st2, st0;
    logic [3:0] ex2, ex0, tt2, tt0;
    logic       a2, b2, y2, busy2, done2, pass2;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic [2:0] ec2, ec0;
    logic [3:0] fm2, fm0;

    // Gate under test: its truth table is a bench variable, bit i = y for {a,b}=i.
    assign y2 = tt2[{a2, b2}];
    assign y0 = tt0[{a0, b0}];

    gate_tt_checker #(.SETTLE(2)) u_s2 (
        .clk(clk), .rst(rst), .start(st2), .expected(ex2), .a(a2), .b(b2), .y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(ec2), .fail_mask(fm2)
    );

    gate_tt_checker #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(st0), .expected(ex0), .a(a0), .b(b0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .fail_mask(fm0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic smp(input int u, output logic [1:0] ab, output logic bz, output logic dn,
                       output logic ps, output logic [2:0] ec, output logic [3:0] fm);
        if (u == 0) begin
            ab = {a2, b2}; bz = busy2; dn = done2; ps = pass2; ec = ec2; fm = fm2;
        end else begin
            ab = {a0, b0}; bz = busy0; dn = done0; ps = pass0; ec = ec0; fm = fm0;
        end
    endtask

    task automatic drv(input int u, input logic s, input logic [3:0] e, input logic [3:0] t);
        if (u == 0) begin st2 = s; ex2 = e; tt2 = t; end
        else        begin st0 = s; ex0 = e; tt0 = t; end
    endtask

    // One full check on instance u (0: SETTLE=2, 1: SETTLE=0). Optionally
    // re-pulses start at E0+5, which must be ignored.
    task automatic run(input int u, input logic [3:0] t, input logic [3:0] e, input bit restart);
        int         s;
        int         len;
        logic [3:0] m;
        logic [1:0] ab;
        logic       bz, dn, ps;
        logic [2:0] ec;
        logic [3:0] fm;
        s   = (u == 0) ? 2 : 0;
        len = 4 * (s + 1);
        m   = t ^ e;
        @(negedge clk);
        drv(u, 1'b1, e, t);
        @(negedge clk);                       // after E0
        drv(u, 1'b0, 4'($urandom), t);        // scrambled expected must not matter
        smp(u, ab, bz, dn, ps, ec, fm);
        chk("run_busy_e0", 32'(bz), 32'd1);
        chk("run_ab_e0", 32'(ab), 32'd0);
        chk("run_ec_clr", 32'(ec), 32'd0);
        chk("run_fm_clr", 32'(fm), 32'd0);
        for (int k = 1; k < len; k++) begin
            @(negedge clk);                   // after E0+k
            drv(u, (restart && k == 4) ? 1'b1 : 1'b0, 4'($urandom), t);
            smp(u, ab, bz, dn, ps, ec, fm);
            chk("run_ab_step", 32'(ab), 32'(k / (s + 1)));
            chk("run_busy", 32'(bz), 32'd1);
            chk("run_done_early", 32'(dn), 32'd0);
        end
        @(negedge clk);                       // after E0+len: done cycle
        drv(u, 1'b0, 4'($urandom), t);
        smp(u, ab, bz, dn, ps, ec, fm);
        chk("fin_done", 32'(dn), 32'd1);
        chk("fin_busy", 32'(bz), 32'd0);
        chk("fin_pass", 32'(ps), 32'(m == 4'd0));
        chk("fin_err", 32'(ec), 32'($countones(m)));
        chk("fin_mask", 32'(fm), 32'(m));
        chk("fin_ab", 32'(ab), 32'd0);
        @(negedge clk);
        smp(u, ab, bz, dn, ps, ec, fm);
        chk("post_done", 32'(dn), 32'd0);
        chk("post_busy", 32'(bz), 32'd0);
        chk("hold_pass", 32'(ps), 32'(m == 4'd0));
        chk("hold_err", 32'(ec), 32'($countones(m)));
        chk("hold_mask", 32'(fm), 32'(m));
        if (restart) begin
            for (int k = 0; k < len + 2; k++) begin
                @(negedge clk);
                smp(u, ab, bz, dn, ps, ec, fm);
                chk("norestart_done", 32'(dn), 32'd0);
                chk("norestart_busy", 32'(bz), 32'd0);
            end
        end
    endtask

    initial begin
        logic [1:0] ab;
        logic       bz, dn, ps;
        logic [2:0] ec;
        logic [3:0] fm;
        logic [3:0] rt, re;

        rst = 1'b1;
        drv(0, 1'b0, 4'd0, 4'b0111);
        drv(1, 1'b0, 4'd0, 4'b0111);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            smp(u, ab, bz, dn, ps, ec, fm);
            chk("rst_ab", 32'(ab), 32'd0);
            chk("rst_busy", 32'(bz), 32'd0);
            chk("rst_done", 32'(dn), 32'd0);
            chk("rst_pass", 32'(ps), 32'd0);
            chk("rst_err", 32'(ec), 32'd0);
            chk("rst_mask", 32'(fm), 32'd0);
        end

        // Reset wins over start in the same cycle.
        st2 = 1'b1;
        @(negedge clk);
        chk("rst_prio_busy", 32'(busy2), 32'd0);
        st2 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy2), 32'd0);

        run(0, 4'b0111, 4'b0111, 1'b0);       // correct NAND
        run(0, 4'b0111, 4'b1000, 1'b0);       // wrong table
        run(0, 4'b1111, 4'b0111, 1'b0);       // y stuck at 1
        run(0, 4'b0111, 4'b0111, 1'b1);       // start while busy

        // Mid-run reset at E0+6, after vector 0 already mismatched.
        @(negedge clk);
        drv(0, 1'b1, 4'b1000, 4'b0111);
        @(negedge clk);
        drv(0, 1'b0, 4'b1000, 4'b0111);
        repeat (5) @(negedge clk);            // after E0+5
        chk("mid_err_pre", 32'(ec2), 32'd1);
        chk("mid_mask_pre", 32'(fm2), 32'b0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        smp(0, ab, bz, dn, ps, ec, fm);
        chk("mid_busy", 32'(bz), 32'd0);
        chk("mid_ab", 32'(ab), 32'd0);
        chk("mid_err", 32'(ec), 32'd0);
        chk("mid_mask", 32'(fm), 32'd0);
        chk("mid_pass", 32'(ps), 32'd0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done2), 32'd0);
        end
        run(0, 4'b0111, 4'b0110, 1'b0);

        run(1, 4'b0111, 4'b0111, 1'b0);       // SETTLE=0 correct NAND
        run(1, 4'b0001, 4'b0111, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rt = 4'($urandom);
            re = 4'($urandom);
            run(i % 2, rt, re, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
